// File: rtl/cmp_pair_feeder.sv
// Streaming wrapper around a combinational pair comparator: operand FIFO, registered
// comparator drive, captured result handshake and hit counter. Optional res_eq: CMP_FEEDER_EQ_FLAG_EN.
module cmp_pair_feeder #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] cmp_a,
    output logic [W-1:0] cmp_b,
    input  logic         cmp_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_out,
    output logic [W-1:0] res_a,
    output logic [W-1:0] res_b,
`ifdef CMP_FEEDER_EQ_FLAG_EN
    output logic         res_eq,
`endif
    output logic [7:0]   hit_cnt
);

    typedef enum logic [1:0] {IDLE, PRESENT, RESULT} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        state;
    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign in_ready = (count != FULL);
    assign push     = in_valid & in_ready;
    // Pop decision uses the registered count, so a push into an empty FIFO waits one edge.
    assign pop      = (count != '0) &&
                      ((state == IDLE) || ((state == RESULT) && res_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmp_a     <= '0;
            cmp_b     <= '0;
            res_valid <= 1'b0;
            res_out   <= 1'b0;
            res_a     <= '0;
            res_b     <= '0;
            hit_cnt   <= '0;
`ifdef CMP_FEEDER_EQ_FLAG_EN
            res_eq    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmp_a <= mem_a[rd_ptr];
                        cmp_b <= mem_b[rd_ptr];
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    res_out   <= cmp_out;
                    res_a     <= cmp_a;
                    res_b     <= cmp_b;
                    res_valid <= 1'b1;
`ifdef CMP_FEEDER_EQ_FLAG_EN
                    res_eq    <= (cmp_a == cmp_b);
`endif
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        if (res_out && (hit_cnt != 8'hFF)) hit_cnt <= hit_cnt + 8'd1;
                        res_valid <= 1'b0;
                        if (pop) begin
                            cmp_a <= mem_a[rd_ptr];
                            cmp_b <= mem_b[rd_ptr];
                            state <= PRESENT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_pair_feeder.sv
// Scoreboard bench for cmp_pair_feeder with a behavioural unsigned greater-than comparator.
module tb_cmp_pair_feeder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_ready;
    logic [3:0] cmp_a, cmp_b;
    logic       cmp_out;
    logic       res_valid, res_out;
    logic [3:0] res_a, res_b;
    logic [7:0] hit_cnt;
`ifdef CMP_FEEDER_EQ_FLAG_EN
    logic       res_eq;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];
    int exp_hit = 0;

    cmp_pair_feeder #(.W(4), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_out(cmp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .res_a(res_a), .res_b(res_b),
`ifdef CMP_FEEDER_EQ_FLAG_EN
        .res_eq(res_eq),
`endif
        .hit_cnt(hit_cnt)
    );

    assign cmp_out = (cmp_a > cmp_b);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        logic acc;
        int n;
        in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        res_ready = 1'b1;
        while ((sb.size() != 0 || res_valid) && n < 300) begin
            cyc(1);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
    endtask

    // Output monitor: records accepted pairs, checks accepted results and stall stability.
    initial begin
        logic       held;
        logic [3:0] h_a, h_b;
        logic       h_o;
        logic [9:0] e;
        held = 1'b0; h_a = '0; h_b = '0; h_o = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb.delete();
                exp_hit = 0;
                held = 1'b0;
            end else begin
                if (held && res_valid) begin
                    chk("hold_a", res_a, h_a);
                    chk("hold_b", res_b, h_b);
                    chk("hold_out", res_out, h_o);
                end
                if (in_valid && in_ready)
                    sb.push_back({in_a, in_b, in_a > in_b, in_a == in_b});
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_a", res_a, e[9:6]);
                        chk("res_b", res_b, e[5:2]);
                        chk("res_out", res_out, e[1]);
`ifdef CMP_FEEDER_EQ_FLAG_EN
                        chk("res_eq", res_eq, e[0]);
`endif
                        chk("hit_cnt_run", hit_cnt, exp_hit);
                        if (e[1] && exp_hit < 255) exp_hit++;
                    end
                end
                held = res_valid && !res_ready;
                h_a = res_a; h_b = res_b; h_o = res_out;
            end
        end
    end

    initial begin
        // reset with random inputs
        #1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom);
            res_ready = 1'($urandom);
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            cyc(1);
            chk("rst_valid", res_valid, 0);
            chk("rst_hit", hit_cnt, 0);
            chk("rst_cmp_a", cmp_a, 0);
            chk("rst_cmp_b", cmp_b, 0);
            chk("rst_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        res_ready = 1'b0;
        reset_n = 1'b1;
        cyc(1);
        chk("post_rst_in_ready", in_ready, 1);

        // single pair latency
        res_ready = 1'b1;
        in_a = 4'd1; in_b = 4'd14; in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        chk("lat_e0_valid", res_valid, 0);
        cyc(1);
        chk("lat_e1_valid", res_valid, 0);
        chk("lat_e1_cmp_a", cmp_a, 1);
        chk("lat_e1_cmp_b", cmp_b, 14);
        cyc(1);
        chk("lat_e2_valid", res_valid, 1);
        chk("lat_e2_res_a", res_a, 1);
        chk("lat_e2_res_b", res_b, 14);
        chk("lat_e2_res_out", res_out, 0);
        push(4'd14, 4'd11);
        drain();
        chk("single_hit", hit_cnt, 1);

        // burst under backpressure
        res_ready = 1'b0;
        push(4'd15, 4'd14);
        push(4'd15, 4'd15);
        push(4'd6, 4'd7);
        push(4'd0, 4'd0);
        push(4'd3, 4'd2);
        chk("burst_full", in_ready, 0);
        in_a = 4'd8; in_b = 4'd8; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("burst_stall_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        push(4'd8, 4'd8);
        drain();
        chk("burst_hit", hit_cnt, 3);

        // simultaneous push and pop at count 2 in RESULT
        res_ready = 1'b0;
        push(4'd1, 4'd2);
        push(4'd3, 4'd4);
        push(4'd5, 4'd6);
        chk("sim_pre_valid", res_valid, 1);
        in_a = 4'd7; in_b = 4'd0; in_valid = 1'b1; res_ready = 1'b1;
        cyc(1);
        in_valid = 1'b0; res_ready = 1'b0;
        chk("sim_cmp_a", cmp_a, 3);
        chk("sim_cmp_b", cmp_b, 4);
        chk("sim_in_ready", in_ready, 1);
        drain();
        chk("sim_hit", hit_cnt, 4);

        // saturation
        res_ready = 1'b1;
        for (int i = 0; i < 260; i++) push(4'd9, 4'd1);
        drain();
        chk("sat_hit", hit_cnt, 255);

        // reset mid-operation
        res_ready = 1'b0;
        push(4'd2, 4'd3);
        push(4'd4, 4'd1);
        push(4'd6, 4'd6);
        push(4'd1, 4'd0);
        chk("mid_pre_valid", res_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_hit", hit_cnt, 0);
        chk("mid_rst_cmp_a", cmp_a, 0);
        chk("mid_rst_cmp_b", cmp_b, 0);
        chk("mid_rst_res_a", res_a, 0);
        chk("mid_rst_res_b", res_b, 0);
        chk("mid_rst_res_out", res_out, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        cyc(2);
        reset_n = 1'b1;
        res_ready = 1'b1;
        cyc(3);
        chk("no_stale_valid", res_valid, 0);
        in_a = 4'd5; in_b = 4'd2; in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(1);
        chk("mid_lat_e1_valid", res_valid, 0);
        cyc(1);
        chk("mid_lat_e2_valid", res_valid, 1);
        chk("mid_lat_res_out", res_out, 1);
        drain();
        chk("mid_final_hit", hit_cnt, 1);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
